// File: rtl/mc_ctrl_if.sv
// Instruction/data memory request-ready handshake between the main controller and memories.
interface mc_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;

    modport master (output imem_req, output dmem_req, input imem_ready, input dmem_ready);
    modport slave  (input imem_req, input dmem_req, output imem_ready, output dmem_ready);
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing plus a fixed-latency multiply wait.
// state | meaning: 0 FETCH ifetch | 1 DECODE jumps | 2 EXEC alu/branch | 3 MEM dmem access | 4 WB rf write | 5 MDWAIT multiply
module mc_ctrl #(
    parameter int MD_CYCLES = 5,
    parameter int EN_MD     = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    mc_ctrl_if.master        mem,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCWr,
    output logic             IRWr,
    output logic             DRWr,
    output logic             DMWr,
    output logic             RFWr,
    output logic [1:0]       ALUOp,
    output logic [1:0]       EXTOp,
    output logic [1:0]       NPCOp,
    output logic [1:0]       WRSel,
    output logic [1:0]       WDSel,
    output logic             HLSel,
    output logic             BSel,
    output logic             md_start,
    output logic             md_busy,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_MDWAIT = 3'd5;

    localparam logic md_en = (EN_MD != 0);

    logic [2:0] cur, nxt;
    logic [7:0] md_cnt;

    logic is_r, d_addu, d_subu, d_jr, d_mult, d_mfhi, d_mflo;
    logic d_ori, d_lw, d_sw, d_beq, d_bne, d_lui, d_j, d_jal, legal;
    logic [1:0] alu_sel, ext_sel;
    logic       b_sel;

    assign is_r   = (opcode == 6'b000000);
    assign d_addu = is_r && (funct == 6'b100001);
    assign d_subu = is_r && (funct == 6'b100011);
    assign d_jr   = is_r && (funct == 6'b001000);
    assign d_mult = md_en && is_r && ((funct == 6'b011000) || (funct == 6'b011001));
    assign d_mfhi = md_en && is_r && (funct == 6'b010000);
    assign d_mflo = md_en && is_r && (funct == 6'b010010);
    assign d_ori  = (opcode == 6'b001101);
    assign d_lw   = (opcode == 6'b100011);
    assign d_sw   = (opcode == 6'b101011);
    assign d_beq  = (opcode == 6'b000100);
    assign d_bne  = (opcode == 6'b000101);
    assign d_lui  = (opcode == 6'b001111);
    assign d_j    = (opcode == 6'b000010);
    assign d_jal  = (opcode == 6'b000011);
    assign legal  = d_addu || d_subu || d_jr || d_mult || d_mfhi || d_mflo || d_ori ||
                    d_lw || d_sw || d_beq || d_bne || d_lui || d_j || d_jal;

    // ALU/extender controls stay valid from EXEC through MEM and WB so the datapath result holds
    assign alu_sel = (d_subu || d_beq || d_bne) ? 2'b01 : (d_ori ? 2'b10 : 2'b00);
    assign ext_sel = (d_lw || d_sw || d_beq || d_bne) ? 2'b01 : (d_lui ? 2'b10 : 2'b00);
    assign b_sel   = d_ori || d_lw || d_sw || d_lui;

    always_comb begin
        nxt          = cur;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        PCWr         = 1'b0;
        IRWr         = 1'b0;
        DRWr         = 1'b0;
        DMWr         = 1'b0;
        RFWr         = 1'b0;
        ALUOp        = 2'b00;
        EXTOp        = 2'b00;
        NPCOp        = 2'b00;
        WRSel        = 2'b00;
        WDSel        = 2'b00;
        HLSel        = 1'b0;
        BSel         = 1'b0;
        md_start     = 1'b0;
        md_busy      = 1'b0;
        illegal      = 1'b0;
        instr_done   = 1'b0;
        // Outputs are forced low while reset is held so pending requests drop at once
        if (reset_n) begin
            case (cur)
                S_FETCH: begin
                    mem.imem_req = 1'b1;
                    if (mem.imem_ready) begin
                        IRWr = 1'b1;
                        PCWr = 1'b1;
                        nxt  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        illegal = 1'b1;
                        nxt     = S_FETCH;
                    end else if (d_j || d_jal) begin
                        PCWr       = 1'b1;
                        NPCOp      = 2'b10;
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                        if (d_jal) begin
                            RFWr  = 1'b1;
                            WRSel = 2'b10;
                            WDSel = 2'b10;
                        end
                    end else if (d_jr) begin
                        PCWr       = 1'b1;
                        NPCOp      = 2'b11;
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end else begin
                        nxt = S_EXEC;
                    end
                end
                S_EXEC: begin
                    ALUOp = alu_sel;
                    EXTOp = ext_sel;
                    BSel  = b_sel;
                    if (d_beq || d_bne) begin
                        PCWr       = d_beq ? zero : ~zero;
                        NPCOp      = 2'b01;
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end else if (d_lw || d_sw) begin
                        nxt = S_MEM;
                    end else if (d_mult) begin
                        md_start = 1'b1;
                        nxt      = S_MDWAIT;
                    end else begin
                        nxt = S_WB;
                    end
                end
                S_MEM: begin
                    ALUOp        = alu_sel;
                    EXTOp        = ext_sel;
                    BSel         = b_sel;
                    mem.dmem_req = 1'b1;
                    DMWr         = d_sw;
                    if (mem.dmem_ready) begin
                        if (d_sw) begin
                            instr_done = 1'b1;
                            nxt        = S_FETCH;
                        end else begin
                            DRWr = 1'b1;
                            nxt  = S_WB;
                        end
                    end
                end
                S_WB: begin
                    ALUOp      = alu_sel;
                    EXTOp      = ext_sel;
                    BSel       = b_sel;
                    RFWr       = 1'b1;
                    WRSel      = is_r ? 2'b01 : 2'b00;
                    WDSel      = d_lw ? 2'b01 : ((d_mfhi || d_mflo) ? 2'b11 : 2'b00);
                    HLSel      = d_mfhi;
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end
                S_MDWAIT: begin
                    md_busy = 1'b1;
                    if (md_cnt == 8'd0) begin
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end
                end
                default: nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur     <= S_FETCH;
            md_cnt  <= 8'd0;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_EXEC && md_start)
                md_cnt <= 8'(MD_CYCLES - 1);
            else if (cur == S_MDWAIT && md_cnt != 8'd0)
                md_cnt <= md_cnt - 8'd1;
            if (instr_done)
                retired <= retired + CNT_W'(1);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: per-instruction expected cycle sequences built from the instruction set rules.
module tb_mc_ctrl;

    typedef struct packed {
        logic       imem_req, dmem_req, PCWr, IRWr, DRWr, DMWr, RFWr;
        logic [1:0] ALUOp, EXTOp, NPCOp, WRSel, WDSel;
        logic       HLSel, BSel, md_start, md_busy, illegal, instr_done;
        logic [2:0] state;
    } outs_t;

    localparam int MDC = 5;
    localparam int K_ALUR = 0, K_JR = 1, K_MULT = 2, K_MFHI = 3, K_MFLO = 4, K_ORI = 5, K_LW = 6;
    localparam int K_SW = 7, K_BEQ = 8, K_BNE = 9, K_LUI = 10, K_J = 11, K_JAL = 12, K_ILL = 13;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic zero = 1'b0, imem_rdy = 1'b0, dmem_rdy = 1'b0;
    logic sel = 1'b0;
    int   total = 0, bad = 0;
    int unsigned model_ret = 0;

    always #5 clk = ~clk;

    mc_ctrl_if bus0();
    mc_ctrl_if bus1();
    assign bus0.imem_ready = imem_rdy;
    assign bus0.dmem_ready = dmem_rdy;
    assign bus1.imem_ready = imem_rdy;
    assign bus1.dmem_ready = dmem_rdy;

    logic PCWr0, IRWr0, DRWr0, DMWr0, RFWr0, HLSel0, BSel0, md_start0, md_busy0, illegal0, instr_done0;
    logic PCWr1, IRWr1, DRWr1, DMWr1, RFWr1, HLSel1, BSel1, md_start1, md_busy1, illegal1, instr_done1;
    logic [1:0] ALUOp0, EXTOp0, NPCOp0, WRSel0, WDSel0, ALUOp1, EXTOp1, NPCOp1, WRSel1, WDSel1;
    logic [2:0] state0, state1;
    logic [31:0] retired0;
    logic [2:0]  retired1;

    mc_ctrl #(.MD_CYCLES(MDC), .EN_MD(1), .CNT_W(32)) dut0 (
        .clk(clk), .reset_n(reset_n), .mem(bus0.master), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWr(PCWr0), .IRWr(IRWr0), .DRWr(DRWr0), .DMWr(DMWr0), .RFWr(RFWr0), .ALUOp(ALUOp0),
        .EXTOp(EXTOp0), .NPCOp(NPCOp0), .WRSel(WRSel0), .WDSel(WDSel0), .HLSel(HLSel0), .BSel(BSel0),
        .md_start(md_start0), .md_busy(md_busy0), .illegal(illegal0), .instr_done(instr_done0),
        .retired(retired0), .state(state0));

    mc_ctrl #(.MD_CYCLES(MDC), .EN_MD(0), .CNT_W(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .mem(bus1.master), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWr(PCWr1), .IRWr(IRWr1), .DRWr(DRWr1), .DMWr(DMWr1), .RFWr(RFWr1), .ALUOp(ALUOp1),
        .EXTOp(EXTOp1), .NPCOp(NPCOp1), .WRSel(WRSel1), .WDSel(WDSel1), .HLSel(HLSel1), .BSel(BSel1),
        .md_start(md_start1), .md_busy(md_busy1), .illegal(illegal1), .instr_done(instr_done1),
        .retired(retired1), .state(state1));

    outs_t g0, g1, got;
    logic [31:0] ret;
    assign g0 = {bus0.imem_req, bus0.dmem_req, PCWr0, IRWr0, DRWr0, DMWr0, RFWr0, ALUOp0, EXTOp0,
                 NPCOp0, WRSel0, WDSel0, HLSel0, BSel0, md_start0, md_busy0, illegal0, instr_done0, state0};
    assign g1 = {bus1.imem_req, bus1.dmem_req, PCWr1, IRWr1, DRWr1, DMWr1, RFWr1, ALUOp1, EXTOp1,
                 NPCOp1, WRSel1, WDSel1, HLSel1, BSel1, md_start1, md_busy1, illegal1, instr_done1, state1};
    assign got = sel ? g1 : g0;
    assign ret = sel ? {29'd0, retired1} : retired0;

    logic [5:0] op_tab [18];
    logic [5:0] fn_tab [18];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn, input bit en_md);
        case (op)
            6'h00: case (fn)
                6'h21, 6'h23: return K_ALUR;
                6'h08:        return K_JR;
                6'h18, 6'h19: return en_md ? K_MULT : K_ILL;
                6'h10:        return en_md ? K_MFHI : K_ILL;
                6'h12:        return en_md ? K_MFLO : K_ILL;
                default:      return K_ILL;
            endcase
            6'h0d:   return K_ORI;
            6'h23:   return K_LW;
            6'h2b:   return K_SW;
            6'h04:   return K_BEQ;
            6'h05:   return K_BNE;
            6'h0f:   return K_LUI;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    // Compare one cycle (masked), account retirement, then move to the next falling edge
    task automatic cycle(input outs_t e, input outs_t m, input string tag);
        logic [31:0] rmask;
        rmask = sel ? 32'h7 : 32'hffff_ffff;
        #1;
        check_val(tag, 64'(got & m), 64'(e & m));
        check_val({tag, "_ret"}, 64'(ret), 64'(model_ret & rmask));
        if (e.instr_done) model_ret++;
        @(negedge clk);
    endtask

    task automatic strays();
        imem_rdy = 1'($urandom_range(0, 1));
        dmem_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int idly, input int ddly);
        int k;
        outs_t e, attrs, all, mmem;
        k = classify(op, fn, !sel);
        opcode = op; funct = fn; zero = z;
        all = '1;
        mmem = '1; mmem.ALUOp = '0; mmem.EXTOp = '0; mmem.BSel = 1'b0;
        attrs = '0;
        attrs.ALUOp = (k == K_BEQ || k == K_BNE || (k == K_ALUR && fn == 6'h23)) ? 2'd1 : (k == K_ORI ? 2'd2 : 2'd0);
        attrs.EXTOp = (k == K_LW || k == K_SW || k == K_BEQ || k == K_BNE) ? 2'd1 : (k == K_LUI ? 2'd2 : 2'd0);
        attrs.BSel  = (k == K_ORI || k == K_LW || k == K_SW || k == K_LUI);

        for (int i = 0; i <= idly; i++) begin
            imem_rdy = (i == idly); dmem_rdy = 1'($urandom_range(0, 1));
            e = '0; e.imem_req = 1'b1; e.state = 3'd0;
            if (i == idly) begin e.IRWr = 1'b1; e.PCWr = 1'b1; end
            cycle(e, all, "fetch");
        end

        strays();
        e = '0; e.state = 3'd1;
        if (k == K_ILL) e.illegal = 1'b1;
        if (k == K_J || k == K_JAL) begin e.PCWr = 1'b1; e.NPCOp = 2'd2; e.instr_done = 1'b1; end
        if (k == K_JAL) begin e.RFWr = 1'b1; e.WRSel = 2'd2; e.WDSel = 2'd2; end
        if (k == K_JR) begin e.PCWr = 1'b1; e.NPCOp = 2'd3; e.instr_done = 1'b1; end
        cycle(e, all, "decode");
        if (k == K_ILL || k == K_J || k == K_JAL || k == K_JR) return;

        strays();
        e = attrs; e.state = 3'd2;
        if (k == K_BEQ || k == K_BNE) begin
            e.PCWr = (k == K_BEQ) ? z : !z; e.NPCOp = 2'd1; e.instr_done = 1'b1;
        end
        if (k == K_MULT) e.md_start = 1'b1;
        cycle(e, all, "exec");
        if (k == K_BEQ || k == K_BNE) return;

        if (k == K_MULT) begin
            for (int i = 0; i < MDC; i++) begin
                strays();
                e = '0; e.state = 3'd5; e.md_busy = 1'b1; e.instr_done = (i == MDC - 1);
                cycle(e, all, "mdwait");
            end
            return;
        end

        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= ddly; i++) begin
                dmem_rdy = (i == ddly); imem_rdy = 1'($urandom_range(0, 1));
                e = attrs; e.state = 3'd3; e.dmem_req = 1'b1; e.DMWr = (k == K_SW);
                if (i == ddly) begin
                    if (k == K_SW) e.instr_done = 1'b1; else e.DRWr = 1'b1;
                end
                cycle(e, mmem, "mem");
            end
            if (k == K_SW) return;
        end

        strays();
        e = attrs; e.state = 3'd4; e.RFWr = 1'b1; e.instr_done = 1'b1;
        e.WRSel = (op == 6'h00) ? 2'd1 : 2'd0;
        e.WDSel = (k == K_LW) ? 2'd1 : ((k == K_MFHI || k == K_MFLO) ? 2'd3 : 2'd0);
        e.HLSel = (k == K_MFHI);
        cycle(e, all, "wb");
    endtask

    task automatic run_rand(input int n);
        int idx;
        for (int i = 0; i < n; i++) begin
            idx = $urandom_range(0, 17);
            run_instr(op_tab[idx], fn_tab[idx], 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        check_val({tag, "_outs"}, 64'(got), 64'd0);
        check_val({tag, "_ret"}, 64'(ret), 64'd0);
        model_ret = 0;
        @(negedge clk);
        imem_rdy = 1'b0; dmem_rdy = 1'b0;
        reset_n = 1'b1;
    endtask

    // Advance until the target state (bounded), spend one more cycle there, then reset mid-cycle
    task automatic abort_in(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] tgt, input string tag);
        int n;
        n = 0;
        opcode = op; funct = fn; imem_rdy = 1'b1; dmem_rdy = 1'b0;
        #1;
        while (got.state != tgt && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check_val({tag, "_reach"}, 64'(got.state), 64'(tgt));
        @(negedge clk);
        do_reset(tag);
    endtask

    initial begin
        op_tab = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h23,
                   6'h2b, 6'h04, 6'h05, 6'h0f, 6'h02, 6'h03, 6'h00, 6'h3f, 6'h08};
        fn_tab = '{6'h21, 6'h23, 6'h08, 6'h18, 6'h19, 6'h10, 6'h12, 6'h15, 6'h00,
                   6'h3a, 6'h11, 6'h00, 6'h2c, 6'h07, 6'h21, 6'h3f, 6'h21, 6'h00};

        repeat (2) @(negedge clk);
        #1;
        check_val("reset_outs", 64'(got), 64'd0);
        check_val("reset_ret", 64'(ret), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_instr(6'h00, 6'h21, 1'b0, 0, 0);
        run_instr(6'h23, 6'h00, 1'b0, 0, 3);
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);
        run_instr(6'h05, 6'h00, 1'b1, 1, 0);
        run_instr(6'h03, 6'h00, 1'b0, 0, 0);
        run_instr(6'h00, 6'h18, 1'b0, 0, 0);
        run_instr(6'h00, 6'h10, 1'b0, 0, 0);
        run_instr(6'h2b, 6'h00, 1'b0, 2, 2);
        run_rand(80);

        abort_in(6'h23, 6'h00, 3'd3, "rst_mem");
        run_instr(6'h0f, 6'h00, 1'b0, 0, 0);
        abort_in(6'h00, 6'h19, 3'd5, "rst_mdwait");
        run_instr(6'h0d, 6'h00, 1'b0, 1, 0);

        sel = 1'b1;
        do_reset("sel1");
        run_instr(6'h00, 6'h18, 1'b0, 0, 0);
        run_instr(6'h00, 6'h12, 1'b0, 0, 0);
        run_instr(6'h00, 6'h23, 1'b0, 0, 0);
        run_rand(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
